// File: rtl/aukv_wb_bridge_if.sv
// Core-request / Wishbone-classic signal bundle for aukv_wb_bridge.
// master: the bridge's view; slave: the surrounding core + Wishbone fabric.
interface aukv_wb_bridge_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned SEL_WIDTH = DATA_WIDTH / 8;

  logic                  req_en_i;
  logic                  req_we_i;
  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic [DATA_WIDTH-1:0] req_data_i;
  logic [SEL_WIDTH-1:0]  req_sel_i;
  logic                  req_ready_o;
  logic                  rsp_valid_o;
  logic [DATA_WIDTH-1:0] rsp_data_o;
  logic                  rsp_err_o;
  logic                  wb_cyc_o;
  logic                  wb_stb_o;
  logic                  wb_we_o;
  logic [ADDR_WIDTH-1:0] wb_addr_o;
  logic [DATA_WIDTH-1:0] wb_data_o;
  logic [SEL_WIDTH-1:0]  wb_sel_o;
  logic [DATA_WIDTH-1:0] wb_data_i;
  logic                  wb_ack_i;

  modport master (
    input  req_en_i, req_we_i, req_addr_i, req_data_i, req_sel_i, wb_data_i, wb_ack_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
           wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_data_o, wb_sel_o
  );

  modport slave (
    output req_en_i, req_we_i, req_addr_i, req_data_i, req_sel_i, wb_data_i, wb_ack_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
           wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_data_o, wb_sel_o
  );
endinterface

// File: rtl/aukv_wb_bridge.sv
// AUK-V en/valid memory port to Wishbone classic master with a 1-entry pending buffer.
// Optional bus-cycle timeout abort enabled by defining BRIDGE_TIMEOUT_EN.
module aukv_wb_bridge #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic              clk,
  input logic              rst,
  aukv_wb_bridge_if.master bus
);
  localparam int unsigned SEL_WIDTH = DATA_WIDTH / 8;

  typedef enum logic {IDLE, BUS} state_t;

  state_t state, state_nx;

  logic accept, launch, use_pend, store_pend, finish, abort, tmo;
  logic pend_valid, pend_valid_nx;

  logic                  pend_we;
  logic [ADDR_WIDTH-1:2] pend_addr;
  logic [DATA_WIDTH-1:0] pend_data;
  logic [SEL_WIDTH-1:0]  pend_sel;

  logic                  ready_q, cyc_q, we_q, rsp_valid_q, rsp_err_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q, rsp_data_q;
  logic [SEL_WIDTH-1:0]  sel_q;

  // Byte-lane bits of the request address never reach the bus.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^bus.req_addr_i[1:0];

  assign accept = bus.req_en_i && ready_q;

`ifdef BRIDGE_TIMEOUT_EN
  localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_WIDTH-1:0] tmo_cnt;

  // Abort in the BUS cycle whose increment would bring the count to TIMEOUT_CYCLES.
  assign tmo = (state == BUS) && (tmo_cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (launch) begin
      tmo_cnt <= '0;
    end else if (state == BUS) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign bus.rsp_err_o = rsp_err_q;
`else
  assign tmo           = 1'b0;
  assign bus.rsp_err_o = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    launch     = 1'b0;
    use_pend   = 1'b0;
    store_pend = 1'b0;
    finish     = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (pend_valid) begin
          launch   = 1'b1;
          use_pend = 1'b1;
          state_nx = BUS;
        end else if (accept) begin
          launch   = 1'b1;
          state_nx = BUS;
        end
      end
      BUS: begin
        store_pend = accept;
        if (bus.wb_ack_i) begin
          finish   = 1'b1;
          state_nx = IDLE;
        end else if (tmo) begin
          abort    = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    pend_valid_nx = (pend_valid && !use_pend) || store_pend;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid  <= 1'b0;
      pend_we     <= 1'b0;
      pend_addr   <= '0;
      pend_data   <= '0;
      pend_sel    <= '0;
      ready_q     <= 1'b1;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      sel_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      pend_valid  <= pend_valid_nx;
      ready_q     <= !pend_valid_nx;
      rsp_valid_q <= finish || abort;
      rsp_err_q   <= abort;
      rsp_data_q  <= (finish && !we_q) ? bus.wb_data_i : '0;
      if (store_pend) begin
        pend_we   <= bus.req_we_i;
        pend_addr <= bus.req_addr_i[ADDR_WIDTH-1:2];
        pend_data <= bus.req_data_i;
        pend_sel  <= bus.req_sel_i;
      end
      if (launch) begin
        cyc_q  <= 1'b1;
        we_q   <= use_pend ? pend_we : bus.req_we_i;
        addr_q <= {(use_pend ? pend_addr : bus.req_addr_i[ADDR_WIDTH-1:2]), 2'b00};
        data_q <= use_pend ? pend_data : bus.req_data_i;
        sel_q  <= use_pend ? pend_sel : bus.req_sel_i;
      end else if (finish || abort) begin
        cyc_q <= 1'b0;
      end
    end
  end

  assign bus.req_ready_o = ready_q;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_data_o  = rsp_data_q;
  assign bus.wb_cyc_o    = cyc_q;
  assign bus.wb_stb_o    = cyc_q;
  assign bus.wb_we_o     = we_q;
  assign bus.wb_addr_o   = addr_q;
  assign bus.wb_data_o   = data_q;
  assign bus.wb_sel_o    = sel_q;
endmodule

// File: tb/tb_aukv_wb_bridge.sv
// Bench for aukv_wb_bridge: cycle-numbered transaction model plus a random Wishbone responder.
// Define BRIDGE_TIMEOUT_EN for both bench and RTL to exercise the timeout build.
module tb_aukv_wb_bridge;
`ifdef BRIDGE_TIMEOUT_EN
  localparam int TB_TMO = 4;
  localparam bit TMO_EN = 1'b1;
`else
  localparam int TB_TMO = 255;
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aukv_wb_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  aukv_wb_bridge #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(TB_TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
    int          acc;
  } req_t;

  typedef struct {
    int          at;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  req_t req_q[$];
  rsp_t rsp_q[$];
  req_t cur;
  bit   cur_act;
  int   cur_start, cur_dly;
  int   t, last_end;
  int   force_dly = -1;
  bit   force_rd = 1'b0;
  logic [31:0] force_rdata = '0;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, t);
  endtask

  // One clock: judge this cycle's outputs against the model, then drive this cycle's inputs.
  task automatic step(input bit en, input bit we, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] sel);
    bit exp_ready, exp_rv, ack;
    rsp_t r;
    logic [31:0] rd;
    @(negedge clk);
    t++;
    if (!cur_act && req_q.size() > 0 && t >= req_q[0].acc + 1 && t >= last_end + 2) begin
      cur       = req_q.pop_front();
      cur_act   = 1'b1;
      cur_start = t;
      cur_dly   = (force_dly >= 0) ? force_dly : int'($urandom_range(5, 0));
    end
    exp_ready = (req_q.size() == 0);
    exp_rv    = (rsp_q.size() > 0) && (rsp_q[0].at == t);
    check("cyc", bus.wb_cyc_o, cur_act);
    check("stb", bus.wb_stb_o, cur_act);
    check("req_ready", bus.req_ready_o, exp_ready);
    check("rsp_valid", bus.rsp_valid_o, exp_rv);
    if (exp_rv) begin
      r = rsp_q.pop_front();
      check("rsp_data", bus.rsp_data_o, r.data);
      check("rsp_err", bus.rsp_err_o, r.err);
    end else begin
      check("rsp_err_quiet", bus.rsp_err_o, 1'b0);
    end
    if (cur_act) begin
      check("wb_we", bus.wb_we_o, cur.we);
      check("wb_addr", bus.wb_addr_o, cur.addr & 32'hFFFF_FFFC);
      check("wb_data", bus.wb_data_o, cur.data);
      check("wb_sel", bus.wb_sel_o, cur.sel);
    end

    rd  = force_rd ? force_rdata : $urandom;
    ack = 1'b0;
    if (cur_act) begin
      if (t == cur_start + cur_dly) begin
        ack = 1'b1;
        rsp_q.push_back('{at: t + 1, data: (cur.we ? 32'h0 : rd), err: 1'b0});
        cur_act  = 1'b0;
        last_end = t;
      end else if (TMO_EN && (t - cur_start + 1 == TB_TMO)) begin
        rsp_q.push_back('{at: t + 1, data: 32'h0, err: 1'b1});
        cur_act  = 1'b0;
        last_end = t;
      end
    end else begin
      ack = 1'($urandom_range(1, 0));
    end
    bus.wb_ack_i   = ack;
    bus.wb_data_i  = rd;
    bus.req_en_i   = en;
    bus.req_we_i   = we;
    bus.req_addr_i = addr;
    bus.req_data_i = data;
    bus.req_sel_i  = sel;
    if (en && exp_ready) req_q.push_back('{we: we, addr: addr, data: data, sel: sel, acc: t});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic model_reset();
    req_q.delete();
    rsp_q.delete();
    cur_act  = 1'b0;
    last_end = t - 10;
  endtask

  initial begin
    bus.req_en_i   = 1'b0;
    bus.req_we_i   = 1'b0;
    bus.req_addr_i = '0;
    bus.req_data_i = '0;
    bus.req_sel_i  = '0;
    bus.wb_ack_i   = 1'b0;
    bus.wb_data_i  = '0;
    t = 0;
    model_reset();

    repeat (2) @(negedge clk);
    check("rst_cyc", bus.wb_cyc_o, 1'b0);
    check("rst_stb", bus.wb_stb_o, 1'b0);
    check("rst_ready", bus.req_ready_o, 1'b1);
    check("rst_rsp_valid", bus.rsp_valid_o, 1'b0);
    check("rst_rsp_err", bus.rsp_err_o, 1'b0);
    check("rst_rsp_data", bus.rsp_data_o, 32'h0);
    check("rst_we", bus.wb_we_o, 1'b0);
    check("rst_addr", bus.wb_addr_o, 32'h0);
    check("rst_wdata", bus.wb_data_o, 32'h0);
    check("rst_sel", bus.wb_sel_o, 4'h0);
    rst = 1'b0;

    // Directed read with ack two cycles after strobe.
    force_dly = 2; force_rd = 1'b1; force_rdata = 32'hCAFEF00D;
    step(1'b1, 1'b0, 32'h104, 32'h0, 4'hF);
    idle(6);
    // Directed unaligned write.
    step(1'b1, 1'b1, 32'h2003, 32'h11223344, 4'b0010);
    idle(6);
    force_rd = 1'b0;
    // Back-to-back: second goes pending, third and fourth are refused.
    force_dly = 3;
    step(1'b1, 1'b0, 32'h300, 32'h0, 4'hF);
    step(1'b1, 1'b1, 32'h404, 32'hA5A5A5A5, 4'h3);
    step(1'b1, 1'b1, 32'h508, 32'h5A5A5A5A, 4'hC);
    step(1'b1, 1'b0, 32'h60C, 32'h0, 4'hF);
    idle(12);
    // Request arriving in the same cycle as ack.
    force_dly = 0;
    step(1'b1, 1'b0, 32'h700, 32'h0, 4'hF);
    step(1'b1, 1'b1, 32'h804, 32'hDEADBEEF, 4'h9);
    idle(8);
    force_dly = -1;

    for (int i = 0; i < 1500; i++)
      step(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), $urandom, $urandom, 4'($urandom));
    idle(10);

    // Ack withheld: held indefinitely, or aborted in the timeout build.
    force_dly = 1000;
    step(1'b1, 1'b0, 32'h900, 32'h0, 4'hF);
    idle(1005);

    // Asynchronous reset in the middle of an open cycle.
    step(1'b1, 1'b1, 32'hA00, 32'h12345678, 4'hF);
    idle(2);
    check("cyc_before_rst", bus.wb_cyc_o, 1'b1);
    #1 rst = 1'b1;
    bus.req_en_i = 1'b0;
    bus.wb_ack_i = 1'b0;
    #1;
    check("async_rst_cyc", bus.wb_cyc_o, 1'b0);
    check("async_rst_stb", bus.wb_stb_o, 1'b0);
    check("async_rst_rsp_valid", bus.rsp_valid_o, 1'b0);
    check("async_rst_ready", bus.req_ready_o, 1'b1);
    @(negedge clk);
    t++;
    rst = 1'b0;
    force_dly = -1;
    model_reset();
    idle(8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
